// File: rtl/pipe_regfile.sv
// Register file for the 5-stage pipeline: one clocked write port, NUM_RD
// combinational read ports, optional WB->ID bypass and a pending-write scoreboard.
module pipe_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int PEND_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ok
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [PEND_W-1:0] pend_q [DEPTH];
  logic [PEND_W-1:0] pend_d [DEPTH];

  logic              inc_vec [DEPTH];
  logic              dec_vec [DEPTH];

  logic              wr_allowed;
  logic              iss_allowed;
  logic              iss_take;

  // With ZERO_REG, address 0 is never written and never reserved.
  assign wr_allowed  = !((ZERO_REG != 0) && (wr_addr == '0));
  assign iss_allowed = !((ZERO_REG != 0) && (iss_addr == '0));

  // A saturated counter still accepts an issue when the same register retires this cycle.
  always_comb begin
    iss_ok = 1'b1;
    if (iss_allowed && (pend_q[iss_addr] == {PEND_W{1'b1}}) &&
        !(wr_en && (wr_addr == iss_addr)))
      iss_ok = 1'b0;
  end

  assign iss_take = iss_en && iss_ok && iss_allowed;

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      inc_vec[r] = 1'b0;
      dec_vec[r] = 1'b0;
      if (iss_take && (iss_addr == ADDR_W'(r)))
        inc_vec[r] = 1'b1;
      if (wr_en && wr_allowed && (wr_addr == ADDR_W'(r)) && (pend_q[r] != '0))
        dec_vec[r] = 1'b1;
    end
  end

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
      pend_d[r] = pend_q[r];
    end
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_d[r] = '0;
        pend_d[r] = '0;
      end
    end else begin
      if (wr_en && wr_allowed)
        regs_d[wr_addr] = wr_data;
      for (int r = 0; r < DEPTH; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          pend_d[r] = pend_q[r] + PEND_W'(1);
        else if (dec_vec[r] && !inc_vec[r])
          pend_d[r] = pend_q[r] - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_q[r] <= regs_d[r];
      pend_q[r] <= pend_d[r];
    end
  end

  // Read ports: the zero register overrides bypass, bypass overrides storage.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              wr_hit;

    assign addr    = rd_addr[i*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign wr_hit  = (BYPASS != 0) && wr_en && (wr_addr == addr);

    assign rd_data[i*DATA_W +: DATA_W] = is_zero ? '0 :
                                         wr_hit  ? wr_data : regs_q[addr];

    assign rd_busy[i] = !is_zero && (pend_q[addr] != '0) &&
                        !(wr_hit && (pend_q[addr] == PEND_W'(1)));
  end

endmodule

// File: doc/pipe_regfile.md
Name: pipe_regfile

Overview:
Parametrised register file for the 5-stage MIPS pipeline with a clocked write port and NUM_RD combinational read ports. Optional register 0 is hardwired to zero. Optional write-to-read bypass lets a value written back in the WB stage reach a same-cycle ID read. A per-register pending-write scoreboard (a small counter per register) lets hazard logic in ID stall on operands that are not yet written back.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending
PEND_W, 2, scoreboard counter width; max outstanding writes per register = 2**PEND_W-1

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, combinational
rd_busy  out  NUM_RD  1 = register at port i has an outstanding write not satisfied this cycle
wr_en  in  1  writeback enable (WB stage)
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback data
iss_en  in  1  issue: instruction with destination iss_addr entering EX
iss_addr  in  ADDR_W  destination being reserved
iss_ok  out  1  combinational; 0 = issue refused because the counter is saturated

Behaviour:
- Storage: 2**ADDR_W x DATA_W flops plus a PEND_W-bit pend counter per register.
- Reset: on a clk edge with rst=1, all registers <= 0 and all pend counters <= 0. wr_en and iss_en in that cycle are ignored. Outputs are combinational from state: after reset rd_data=0, rd_busy=0, iss_ok=1.
- Write: on a clk edge with wr_en=1 and rst=0, reg[wr_addr] <= wr_data. Visible at rd_data from the next cycle.
  - A write with pend=0 is legal (untracked write); the counter stays 0.
- Read: rd_data[i] = reg[rd_addr[i]], zero latency.
  - If BYPASS=1, wr_en=1 and wr_addr==rd_addr[i], then rd_data[i] = wr_data.
  - If ZERO_REG=1 and rd_addr[i]==0, then rd_data[i] = 0; this overrides bypass.
- Scoreboard update per register r at each clk edge (rst=0):
  - inc = iss_en & iss_ok & iss_addr==r
  - dec = wr_en & wr_addr==r & pend[r]!=0
  - inc & !dec: pend+1. dec & !inc: pend-1. Both or neither: unchanged.
- iss_ok = 0 only when pend[iss_addr] == all-ones and there is no dec on iss_addr this cycle; otherwise 1. A refused issue changes no state.
- rd_busy[i] = pend[rd_addr[i]]!=0, except:
  - forced 0 when BYPASS=1, pend==1 and the same-cycle write targets rd_addr[i];
  - forced 0 for address 0 when ZERO_REG=1.
- ZERO_REG=1: writes and issues to address 0 are ignored; pend[0] stays 0; iss_ok=1 for address 0.
- Multiple read ports addressing the same register all return identical data and busy.
- Simultaneous write and issue to the same register: data is written and the count is unchanged (old producer retires, new one is reserved).
- No read-during-reset special case; reads return the stored state.

Test Plan:
- Reset: preload state, then rst=1 for one cycle -> every rd_data=0, rd_busy=0, iss_ok=1; a wr_en in the reset cycle leaves the register at 0.
- Write/read: write reg5=0xDEADBEEF, wait one cycle, read on port0 and port1 -> both return 0xDEADBEEF. Write reg0=0x1234 -> reads 0 (ZERO_REG=1).
- Bypass: rd_addr0=7 with wr_en, wr_addr=7, wr_data=0xA5A5A5A5 in the same cycle -> rd_data0=0xA5A5A5A5 that cycle. With BYPASS=0 -> old value that cycle, new value the next.
- Scoreboard: issue r3 twice -> rd_busy=1; writeback r3 once -> still busy; second writeback -> rd_busy=0 in the same cycle (BYPASS=1), pend=0 after the edge.
- Saturation: issue r9 three times (PEND_W=2) -> iss_ok=0 on a 4th issue; the 4th issue with a simultaneous r9 writeback -> iss_ok=1 and the count stays 3.
- Reset mid-operation: pend[4]=2 with rst asserted alongside iss_en=1, iss_addr=4 -> pend[4]=0, rd_busy=0 after the edge.
